// File: rtl/float32_pkg.sv
// Shared types and constants for the float32 accumulator master.
package float32_pkg;

    // Accumulator control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT_Z = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    // Positive zero; the running sum starts from here so the first element
    // goes through the adder like every other one.
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

endpackage : float32_pkg

// File: rtl/float32_accum_master.sv
// Streams float32 elements through an external stb/ack adder and emits the
// running sum plus element count when the element marked last has been added.
//
// Handshakes:
//   in_valid/in_ready   : element transfers at a rising edge where both are 1.
//   sum_valid/sum_ready : sum transfers at a rising edge where both are 1;
//                         sum_data/sum_count hold while sum_valid=1, sum_ready=0.
//   x_stb/x_ack (adder) : the strobing side holds stb and its data until an
//                         edge with stb=1 and ack=1; that edge is the transfer
//                         and stb is 0 from the following cycle.
// Every output comes straight from a register, so no input reaches an output
// combinationally.
module float32_accum_master
    import float32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_a_stb,
    output logic             add_b_stb,
    input  logic             add_a_ack,
    input  logic             add_b_ack,
    input  logic [31:0]      add_z,
    input  logic             add_z_stb,
    output logic             add_z_ack,
    output logic [31:0]      sum_data,
    output logic [CNT_W-1:0] sum_count,
    output logic             sum_valid,
    input  logic             sum_ready,
    output state_t           state_dbg
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    state_t           next_state;
    logic [31:0]      acc;
    logic [CNT_W-1:0] count;
    logic             last_q;

    logic in_take;
    logic a_done;
    logic b_done;
    logic z_take;
    logic out_take;

    assign in_take  = (state == ST_IDLE) && in_ready && in_valid;
    assign a_done   = !add_a_stb || add_a_ack;
    assign b_done   = !add_b_stb || add_b_ack;
    assign z_take   = (state == ST_WAIT_Z) && add_z_stb && add_z_ack;
    assign out_take = (state == ST_OUT) && sum_ready;

    assign sum_data  = acc;
    assign sum_count = count;
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: one element in flight at a time.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (in_take)          next_state = ST_SEND;
            ST_SEND:   if (a_done && b_done) next_state = ST_WAIT_Z;
            ST_WAIT_Z: if (z_take)           next_state = last_q ? ST_OUT : ST_IDLE;
            ST_OUT:    if (out_take)         next_state = ST_IDLE;
            default:                         next_state = ST_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_ready  <= 1'b0;
            add_a     <= FP32_ZERO;
            add_b     <= FP32_ZERO;
            add_a_stb <= 1'b0;
            add_b_stb <= 1'b0;
            add_z_ack <= 1'b0;
            acc       <= FP32_ZERO;
            count     <= '0;
            last_q    <= 1'b0;
            sum_valid <= 1'b0;
        end else begin
            in_ready <= (next_state == ST_IDLE);

            // Operands are loaded once per element and frozen until accepted.
            if (in_take) begin
                add_a     <= acc;
                add_b     <= in_data;
                last_q    <= in_last;
                add_a_stb <= 1'b1;
                add_b_stb <= 1'b1;
            end else begin
                if (add_a_stb && add_a_ack) add_a_stb <= 1'b0;
                if (add_b_stb && add_b_ack) add_b_stb <= 1'b0;
            end

            // Ack the result one cycle after seeing it; the ack falls at the
            // transfer edge, giving a single-cycle pulse inside WAIT_Z only.
            add_z_ack <= (state == ST_WAIT_Z) && add_z_stb && !add_z_ack;

            if (z_take) begin
                acc       <= add_z;
                count     <= (count == CNT_MAX) ? count : count + 1'b1;
                sum_valid <= last_q;
            end

            if (out_take) begin
                acc       <= FP32_ZERO;
                count     <= '0;
                sum_valid <= 1'b0;
            end
        end
    end

endmodule : float32_accum_master

// File: tb/tb_float32_accum_master.sv
// Bench for float32_accum_master: a behavioural stb/ack float adder responder,
// a sum model with expected queues, directed streams and a per-cycle monitor.

// Round-to-nearest-even addition of two non-negative normal float32 values
// (zero operands short-circuit); enough for the operands used here.
function automatic logic [31:0] fp_add_pos(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] p, q;
    logic [63:0] mp, mq, s;
    logic [23:0] m;
    logic [32:0] rem, half;
    logic [8:0]  e;
    logic        sticky;
    int          d;
    if (x[30:0] == 31'd0) return y;
    if (y[30:0] == 31'd0) return x;
    if (x[30:23] >= y[30:23]) begin p = x; q = y; end
    else begin p = y; q = x; end
    d  = int'(p[30:23]) - int'(q[30:23]);
    mp = {40'd0, 1'b1, p[22:0]} << 32;
    mq = {40'd0, 1'b1, q[22:0]} << 32;
    if (d > 40) begin
        sticky = 1'b1;
        mq     = 64'd0;
    end else begin
        sticky = |(mq & ((64'd1 << d) - 64'd1));
        mq     = mq >> d;
    end
    s = mp + mq;
    e = {1'b0, p[30:23]};
    if (s[56]) begin
        m    = s[56:33];
        rem  = s[32:0];
        half = 33'h1_0000_0000;
        e    = e + 9'd1;
    end else begin
        m    = s[55:32];
        rem  = {1'b0, s[31:0]};
        half = 33'h0_8000_0000;
    end
    rem = rem | {32'd0, sticky};
    if (rem > half || (rem == half && m[0])) begin
        m = m + 24'd1;
        if (m == 24'd0) begin
            m = 24'h80_0000;
            e = e + 9'd1;
        end
    end
    return {1'b0, e[7:0], m[22:0]};
endfunction

// Responder adder: acks each operand a programmable number of cycles after
// its strobe rises, then presents the sum z_lat cycles later until acked.
module float32_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic        a_stb,
    output logic        a_ack,
    input  logic [31:0] b,
    input  logic        b_stb,
    output logic        b_ack,
    output logic [31:0] z,
    output logic        z_stb,
    input  logic        z_ack,
    input  int          a_dly,
    input  int          b_dly,
    input  int          z_lat
);
    logic [31:0] ra, rb;
    logic        got_a, got_b;
    int          ca, cb, cz;

    always @(posedge clk) begin
        if (!rst) begin
            a_ack <= 1'b0; b_ack <= 1'b0; z_stb <= 1'b0; z <= 32'd0;
            got_a <= 1'b0; got_b <= 1'b0; ca <= 0; cb <= 0; cz <= 0;
            ra <= 32'd0; rb <= 32'd0;
        end else begin
            if (!a_stb) begin a_ack <= 1'b0; ca <= 0; end
            else if (a_ack) begin ra <= a; got_a <= 1'b1; a_ack <= 1'b0; ca <= 0; end
            else if (ca >= a_dly) a_ack <= 1'b1;
            else ca <= ca + 1;

            if (!b_stb) begin b_ack <= 1'b0; cb <= 0; end
            else if (b_ack) begin rb <= b; got_b <= 1'b1; b_ack <= 1'b0; cb <= 0; end
            else if (cb >= b_dly) b_ack <= 1'b1;
            else cb <= cb + 1;

            if (z_stb) begin
                if (z_ack) z_stb <= 1'b0;
            end else if (got_a && got_b) begin
                if (cz >= z_lat) begin
                    z     <= fp_add_pos(ra, rb);
                    z_stb <= 1'b1;
                    got_a <= 1'b0;
                    got_b <= 1'b0;
                    cz    <= 0;
                end else begin
                    cz <= cz + 1;
                end
            end
        end
    end
endmodule : float32_adder

module tb_float32_accum_master;
    import float32_pkg::*;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic [31:0]      in_data;
    logic             in_last;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      add_a, add_b, add_z;
    logic             add_a_stb, add_b_stb, add_a_ack, add_b_ack;
    logic             add_z_stb, add_z_ack;
    logic [31:0]      sum_data;
    logic [CNT_W-1:0] sum_count;
    logic             sum_valid;
    logic             sum_ready;
    state_t           state_dbg;
    int               a_dly, b_dly, z_lat;

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard: expected sums/counts, one entry per stream.
    logic [31:0] exp_q[$];
    int          exp_cnt_q[$];
    logic [31:0] m_acc;
    int          m_cnt;
    int          m_streams;
    int          n_periods;
    int          split_cnt;

    // Monitor history (sampled on the falling edge).
    logic             prev_rst;
    logic             p_a_stb, p_a_ack, p_b_stb, p_b_ack, p_z_ack;
    logic [31:0]      p_a, p_b, p_sum_data;
    logic [CNT_W-1:0] p_sum_count;
    logic             p_sum_valid, p_sum_ready;

    float32_accum_master #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b), .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
        .add_a_ack(add_a_ack), .add_b_ack(add_b_ack),
        .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
        .sum_data(sum_data), .sum_count(sum_count), .sum_valid(sum_valid),
        .sum_ready(sum_ready), .state_dbg(state_dbg)
    );

    float32_adder u_adder (
        .clk(clk), .rst(rst),
        .a(add_a), .a_stb(add_a_stb), .a_ack(add_a_ack),
        .b(add_b), .b_stb(add_b_stb), .b_ack(add_b_ack),
        .z(add_z), .z_stb(add_z_stb), .z_ack(add_z_ack),
        .a_dly(a_dly), .b_dly(b_dly), .z_lat(z_lat)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected done", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out, expected event did not occur at %0t", name, $time);
    endtask

    // Model: the running sum is the adder applied left to right from +0.0.
    task automatic model_elem(input logic [31:0] d, input logic l);
        m_acc = fp_add_pos(m_acc, d);
        m_cnt++;
        if (l) begin
            exp_q.push_back(m_acc);
            exp_cnt_q.push_back(m_cnt);
            m_streams++;
            m_acc = 32'd0;
            m_cnt = 0;
        end
    endtask

    // Drives one element; called at posedge+1, returns at posedge+1 after the accept.
    task automatic send_elem(input logic [31:0] d, input logic l);
        bit ok;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("in_ready_wait");
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (ok) model_elem(d, l);
    endtask

    // Waits for sum_valid and checks against hand-computed literals.
    task automatic expect_sum(input string name, input logic [31:0] d, input int c);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sum_valid) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now(name);
        else begin
            check({name, "_data"}, sum_data, d);
            check({name, "_count"}, 32'(sum_count), 32'(c));
        end
        @(posedge clk); #1;
    endtask

    // Per-cycle compare: protocol rules and sums against the model.
    always @(negedge clk) begin
        if (prev_rst) begin
            if (p_a_stb && !p_a_ack) begin
                check("a_stb_held", 32'(add_a_stb), 32'd1);
                check("a_stable", add_a, p_a);
            end
            if (p_a_stb && p_a_ack) check("a_stb_drop", 32'(add_a_stb), 32'd0);
            if (p_b_stb && !p_b_ack) begin
                check("b_stb_held", 32'(add_b_stb), 32'd1);
                check("b_stable", add_b, p_b);
            end
            if (p_b_stb && p_b_ack) check("b_stb_drop", 32'(add_b_stb), 32'd0);
            if (p_z_ack) check("z_ack_pulse", 32'(add_z_ack), 32'd0);
            if (add_z_ack) check("z_ack_state", 32'(state_dbg), 32'(ST_WAIT_Z));
            if (p_sum_valid && !p_sum_ready) begin
                check("sum_valid_held", 32'(sum_valid), 32'd1);
                check("sum_data_stable", sum_data, p_sum_data);
                check("sum_count_stable", 32'(sum_count), 32'(p_sum_count));
            end
            if (!add_a_stb && add_b_stb) split_cnt++;
            if (sum_valid && !p_sum_valid) begin
                n_periods++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_sum: got %h with no sum expected at %0t", sum_data, $time);
                end else begin
                    check("model_sum", sum_data, exp_q.pop_front());
                    check("model_count", 32'(sum_count), 32'(exp_cnt_q.pop_front()));
                end
            end
        end
        prev_rst    = rst;
        p_a_stb     = add_a_stb;
        p_a_ack     = add_a_ack;
        p_b_stb     = add_b_stb;
        p_b_ack     = add_b_ack;
        p_z_ack     = add_z_ack;
        p_a         = add_a;
        p_b         = add_b;
        p_sum_data  = sum_data;
        p_sum_count = sum_count;
        p_sum_valid = sum_valid;
        p_sum_ready = sum_ready;
    end

    initial begin
        int split_before;
        prev_rst  = 1'b0;
        m_acc     = 32'd0;
        m_cnt     = 0;
        m_streams = 0;
        n_periods = 0;
        split_cnt = 0;
        rst       = 1'b0;
        in_data   = 32'd0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        sum_ready = 1'b1;
        a_dly     = 0;
        b_dly     = 0;
        z_lat     = 1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_a_stb", 32'(add_a_stb), 32'd0);
        check("rst_b_stb", 32'(add_b_stb), 32'd0);
        check("rst_z_ack", 32'(add_z_ack), 32'd0);
        check("rst_sum_valid", 32'(sum_valid), 32'd0);
        check("rst_add_a", add_a, 32'd0);
        check("rst_add_b", add_b, 32'd0);
        check("rst_sum_data", sum_data, 32'd0);
        check("rst_sum_count", 32'(sum_count), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", 32'(in_ready), 32'd1);

        // Three-element stream: 7.3 + 2 + 4 = 13.3.
        send_elem(32'h40E9999A, 1'b0);
        send_elem(32'h40000000, 1'b0);
        send_elem(32'h40800000, 1'b1);
        expect_sum("stream3", 32'h4154CCCD, 3);
        repeat (5) @(posedge clk);
        #1;
        check("stream3_periods", 32'(n_periods), 32'd1);

        // Single element.
        send_elem(32'h40000000, 1'b1);
        expect_sum("single", 32'h40000000, 1);

        // b acked three cycles after a.
        a_dly = 0;
        b_dly = 3;
        split_before = split_cnt;
        send_elem(32'h40E9999A, 1'b0);
        send_elem(32'h40000000, 1'b0);
        send_elem(32'h40800000, 1'b1);
        expect_sum("b_late", 32'h4154CCCD, 3);
        check("b_late_split_seen", 32'(split_cnt > split_before), 32'd1);

        // a acked after b: 1.0 + 1.0.
        a_dly = 2;
        b_dly = 0;
        z_lat = 0;
        send_elem(32'h3F800000, 1'b0);
        send_elem(32'h3F800000, 1'b1);
        expect_sum("a_late", 32'h40000000, 2);
        a_dly = 0;

        // Back-pressure on the sum with ignored in_valid pulses.
        z_lat     = 3;
        sum_ready = 1'b0;
        send_elem(32'h40400000, 1'b1);
        expect_sum("hold", 32'h40400000, 1);
        for (int i = 0; i < 10; i++) begin
            in_data  = 32'h41200000;
            in_last  = 1'b1;
            in_valid = i[0];
            @(negedge clk);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_valid", 32'(sum_valid), 32'd1);
            check("hold_data", sum_data, 32'h40400000);
            check("hold_count", 32'(sum_count), 32'd1);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        sum_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("hold_released", 32'(sum_valid), 32'd0);
        @(posedge clk); #1;
        send_elem(32'h40000000, 1'b1);
        expect_sum("after_hold", 32'h40000000, 1);

        // Reset while waiting for the adder result.
        z_lat = 8;
        send_elem(32'h40A00000, 1'b0);
        begin
            bit ok;
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (state_dbg == ST_WAIT_Z) begin ok = 1'b1; break; end
            end
            if (!ok) fail_now("reach_wait_z");
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        m_acc = 32'd0;
        m_cnt = 0;
        check("midrst_a_stb", 32'(add_a_stb), 32'd0);
        check("midrst_b_stb", 32'(add_b_stb), 32'd0);
        check("midrst_z_ack", 32'(add_z_ack), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_sum_valid", 32'(sum_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_release_in_ready", 32'(in_ready), 32'd1);
        z_lat = 1;
        send_elem(32'h3F800000, 1'b1);
        expect_sum("after_rst", 32'h3F800000, 1);

        repeat (10) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("period_total", 32'(n_periods), 32'(m_streams));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_float32_accum_master

// File: doc/float32_accum_master.md
FLOAT32_ACCUM_MASTER -- requirements
Module: float32_accum_master

Interface
REQ-001 Parameter: CNT_W, default 16, width of the element counter.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 in_data  input  32  IEEE-754 float32 element to accumulate.
REQ-005 in_last  input  1  marks the final element of a stream.
REQ-006 in_valid  input  1  upstream element valid.
REQ-007 in_ready  output  1  block can accept an element.
REQ-008 add_a, add_b  output  32  operands driven to the external stb/ack float32 adder.
REQ-009 add_a_stb, add_b_stb  output  1  operand strobes to the adder.
REQ-010 add_a_ack, add_b_ack  input  1  operand accept from the adder.
REQ-011 add_z  input  32  adder result.
REQ-012 add_z_stb  input  1  adder result valid.
REQ-013 add_z_ack  output  1  result accept to the adder.
REQ-014 sum_data  output  32  accumulated float32 sum.
REQ-015 sum_count  output  CNT_W  number of elements in sum_data.
REQ-016 sum_valid  output  1  sum_data/sum_count valid.
REQ-017 sum_ready  input  1  downstream accepts sum.

Function
REQ-018 The block SHALL be the initiator of the adder stb/ack protocol.
- States: IDLE, SEND, WAIT_Z, OUT.
REQ-019 IDLE: in_ready=1; on in_valid, latch in_data/in_last and go to SEND next cycle.
REQ-020 SEND: add_a=acc, add_b=latched element; both strobes SHALL be held high until each is individually accepted.
- An operand transfer SHALL occur at an edge where stb and ack are both 1; that strobe SHALL be 0 from the next cycle.
- a and b MAY be accepted in different cycles or the same cycle.
- Go to WAIT_Z once both are accepted.
REQ-021 add_a/add_b SHALL be stable while their strobe is high.
REQ-022 WAIT_Z: on add_z_stb=1, capture add_z into acc, pulse add_z_ack=1 for exactly one cycle, and increment count (saturating at 2^CNT_W-1).
- Next state: OUT if the latched last=1, else IDLE.
REQ-023 add_z_ack SHALL never be 1 outside WAIT_Z; add_z_stb SHALL be ignored in other states.
REQ-024 OUT: sum_valid=1 with sum_data=acc and sum_count=count, held stable until sum_ready=1 at an edge.
- On that edge: acc<=32'h00000000, count<=0, go to IDLE.
REQ-025 in_ready SHALL be 0 in SEND, WAIT_Z and OUT; in_valid there SHALL be ignored.
REQ-026 The first element of a stream SHALL be added to +0.0, so that no special path exists.
REQ-027 Minimum latency from element accept to a result capture is 3 cycles plus the adder latency; there SHALL be no combinational path from inputs to outputs.
REQ-028 Values SHALL pass through bit-exact.
- No float arithmetic inside the block.
- NaN/Inf/denormal handling is the adder's responsibility.

Reset
REQ-029 While rst=0 at an edge:
- state<=IDLE, acc<=0, count<=0.
- add_a_stb, add_b_stb, add_z_ack, sum_valid <= 0.
- add_a, add_b, sum_data <= 0.
- in_ready SHALL be 0 during reset and 1 in the first cycle after release.
REQ-030 Reset mid-transaction (SEND/WAIT_Z/OUT) SHALL abandon it; strobes SHALL be low on the cycle after the reset edge, and any partial sum SHALL be discarded.

Structure
REQ-031 The state enum and FP32_ZERO=32'h00000000 SHALL live in the shared package float32_pkg.
REQ-032 No sub-module; the adder is external. The testbench SHALL instantiate float32_adder as the responder.

Verification
REQ-033 Stream 0x40E9999A, 0x40000000, 0x40800000(last) -> sum_data=0x4154CCCD, sum_count=3, one sum_valid period.
REQ-034 Single element 0x40000000 with last=1 -> sum_data=0x40000000, sum_count=1.
REQ-035 Adder model acks b 3 cycles after a -> add_a_stb drops after its ack, add_b_stb stays high until its own ack, and the result is unchanged.
REQ-036 sum_ready held 0 for 10 cycles -> sum_valid/sum_data stable, in_ready=0, and in_valid pulses are ignored (count unaffected).
REQ-037 rst=0 asserted while in WAIT_Z -> next cycle all strobes 0 and in_ready=1 after release; the following stream 0x3F800000(last) yields 0x3F800000, count=1.
REQ-038 Assertions SHALL check:
- stable operands under strobe;
- add_z_ack is a single-cycle pulse;
- sum outputs are stable while sum_valid=1 and sum_ready=0.
